// File: rtl/lfsr_rd_checker_if.sv
// Read-data beat channel between the AXI master read path and the LFSR checker.
//   s_valid : beat valid (master -> checker)
//   s_ready : checker accepts beat (checker -> master)
//   s_data  : N-bit read-data beat
//   s_last  : final-beat marker from the master
interface lfsr_rd_checker_if #(
  parameter int N = 128
);
  logic         s_valid;
  logic         s_ready;
  logic [N-1:0] s_data;
  logic         s_last;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/lfsr_rd_checker.sv
// LFSR read-data checker.
// Regenerates the XNOR LFSR sequence from SEED and compares it against each
// accepted read-data beat. Counts mismatches (saturating), captures the first
// failing beat, checks s_last placement, and reports pass/fail per run.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : one-cycle pulse that begins a run (honoured only in IDLE)
//   num_beats       : beats in the run, sampled on start
//   rd              : read-data beat channel (slave side)
//   busy            : run in progress (CHECK or DONE)
//   done            : one-cycle end-of-run pulse
//   pass            : result of the last completed run
//   err_cnt         : mismatching beats, saturating
//   first_err_idx   : beat index of the first mismatch
//   first_err_data  : data received at the first mismatch
//   last_err        : s_last was misplaced or missing
module lfsr_rd_checker #(
  parameter int             N     = 128,
  parameter logic [N-1:0]   SEED  = N'(1),
  parameter int             T0    = 98,
  parameter int             T1    = 100,
  parameter int             T2    = 125,
  parameter int             T3    = 127,
  parameter int             CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_beats,
  lfsr_rd_checker_if.slave   rd,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   first_err_idx,
  output logic [N-1:0]       first_err_data,
  output logic               last_err
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [N-1:0]       exp_q, exp_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
  logic [N-1:0]       first_err_data_q, first_err_data_d;
  logic               last_err_q, last_err_d;
  logic               pass_q, pass_d;

  logic               hs;
  logic               is_last;

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
    logic fb;
    fb = ~(v[T0] ^ v[T1] ^ v[T2] ^ v[T3]);
    return {fb, v[N-1:1]};
  endfunction

  assign rd.s_ready = (state_q == CHECK);
  assign hs         = rd.s_valid && (state_q == CHECK);
  // len_q is never 0 while in CHECK, so len_q-1 cannot wrap here
  assign is_last    = (beat_cnt_q == len_q - CNT_W'(1));

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    exp_d            = exp_q;
    beat_cnt_d       = beat_cnt_q;
    err_cnt_d        = err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;
    last_err_d       = last_err_q;
    pass_d           = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d            = num_beats;
          exp_d            = SEED;
          beat_cnt_d       = '0;
          err_cnt_d        = '0;
          first_err_idx_d  = '0;
          first_err_data_d = '0;
          last_err_d       = 1'b0;
          pass_d           = 1'b0;
          state_d          = (num_beats == '0) ? DONE : CHECK;
        end
      end
      CHECK: begin
        if (hs) begin
          if (rd.s_data != exp_q) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            if (err_cnt_q == '0) begin
              first_err_idx_d  = beat_cnt_q;
              first_err_data_d = rd.s_data;
            end
          end
          // expected stream free-runs; never resynced to received data
          exp_d      = lfsr_step(exp_q);
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (rd.s_last != is_last) last_err_d = 1'b1;
          if (is_last) state_d = DONE;
        end
      end
      DONE: begin
        // registers already include the final beat's update
        pass_d  = (err_cnt_q == '0) && !last_err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      len_q            <= '0;
      exp_q            <= SEED;
      beat_cnt_q       <= '0;
      err_cnt_q        <= '0;
      first_err_idx_q  <= '0;
      first_err_data_q <= '0;
      last_err_q       <= 1'b0;
      pass_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      exp_q            <= exp_d;
      beat_cnt_q       <= beat_cnt_d;
      err_cnt_q        <= err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
      last_err_q       <= last_err_d;
      pass_q           <= pass_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign last_err       = last_err_q;

endmodule
